// File: rtl/i2c_pkg.sv
// Shared constants and FSM encoding for the I2C EEPROM block sequencer.
package i2c_pkg;

    localparam logic [4:0]  MAX_LEN           = 5'd16;
    localparam int unsigned MAX_RETRY_DEFAULT = 3;
    localparam int unsigned WR_GAP_DEFAULT    = 100000;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StIssue,
        StWait,
        StDeliver,
        StGap,
        StFinish
    } state_e;

    function automatic logic [4:0] clamp_len(input logic [4:0] len);
        return (len > MAX_LEN) ? MAX_LEN : len;
    endfunction

endpackage

// File: rtl/i2c_block_sequencer_if.sv
// Request, data-stream, status and i2c_master signals of the block sequencer.
interface i2c_block_sequencer_if;

    logic       req_valid;
    logic       req_ready;
    logic       req_rw;
    logic [6:0] req_addr;
    logic [7:0] req_start;
    logic [4:0] req_len;

    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;

    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;

    logic       done;
    logic       fail;
    logic [4:0] bytes_done;

    logic       m_start;
    logic       m_rw;
    logic [6:0] m_addr;
    logic [7:0] m_byte_address;
    logic [7:0] m_din;
    logic [7:0] m_dout;
    logic       m_byte_done;
    logic       m_error;

    // Sequencer side.
    modport slave (
        input  req_valid, req_rw, req_addr, req_start, req_len,
        input  wr_data, wr_valid, rd_ready,
        input  m_dout, m_byte_done, m_error,
        output req_ready, wr_ready, rd_data, rd_valid, done, fail, bytes_done,
        output m_start, m_rw, m_addr, m_byte_address, m_din
    );

    // Requester / i2c_master side.
    modport master (
        output req_valid, req_rw, req_addr, req_start, req_len,
        output wr_data, wr_valid, rd_ready,
        output m_dout, m_byte_done, m_error,
        input  req_ready, wr_ready, rd_data, rd_valid, done, fail, bytes_done,
        input  m_start, m_rw, m_addr, m_byte_address, m_din
    );

endinterface

// File: rtl/i2c_block_sequencer_gap_timer.sv
// Down-counter that holds off the next write for the EEPROM write-cycle time.
module i2c_block_sequencer_gap_timer #(
    parameter int unsigned CYCLES = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_count,
    output logic o_expire
);

    localparam logic [31:0] LoadVal = (CYCLES > 0) ? 32'(CYCLES - 1) : 32'd0;

    logic [31:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LoadVal;
        end else if (i_count && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 32'd1;
        end
    end

    assign o_expire = i_count && (r_cnt == '0);

endmodule

// File: rtl/i2c_block_sequencer.sv
// Splits a block read/write request into single-byte i2c_master transactions with retry.
module i2c_block_sequencer
    import i2c_pkg::*;
#(
    parameter int unsigned MAX_RETRY = MAX_RETRY_DEFAULT,
    parameter int unsigned WR_GAP    = WR_GAP_DEFAULT
) (
    input logic                   i_clk,
    input logic                   i_rst,
    i2c_block_sequencer_if.slave  io_bus
);

    state_e     r_state, w_state_d;
    logic       r_live;
    logic       r_rw, w_rw_d;
    logic [6:0] r_addr, w_addr_d;
    logic [7:0] r_byte_addr, w_byte_addr_d;
    logic [7:0] r_din, w_din_d;
    logic [7:0] r_rd_data, w_rd_data_d;
    logic [4:0] r_len, w_len_d;
    logic [4:0] r_bytes_done, w_bytes_done_d;
    logic [7:0] r_retry, w_retry_d;
    logic       r_fail, w_fail_d;

    logic       w_req_ready;
    logic       w_gap_load;
    logic       w_gap_expire;
    logic       w_advance;
    logic [4:0] w_bytes_inc;
    logic [4:0] w_req_len;

    // r_live keeps req_ready low until the first cycle after reset is released.
    assign w_req_ready = (r_state == StIdle) && r_live && !i_rst;
    assign w_bytes_inc = r_bytes_done + 5'd1;
    assign w_req_len   = clamp_len(io_bus.req_len);

    always_comb begin
        w_state_d      = r_state;
        w_rw_d         = r_rw;
        w_addr_d       = r_addr;
        w_byte_addr_d  = r_byte_addr;
        w_din_d        = r_din;
        w_rd_data_d    = r_rd_data;
        w_len_d        = r_len;
        w_bytes_done_d = r_bytes_done;
        w_retry_d      = r_retry;
        w_fail_d       = 1'b0;
        w_gap_load     = 1'b0;
        w_advance      = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (io_bus.req_valid && w_req_ready) begin
                    w_rw_d         = io_bus.req_rw;
                    w_addr_d       = io_bus.req_addr;
                    w_byte_addr_d  = io_bus.req_start;
                    w_len_d        = w_req_len;
                    w_bytes_done_d = '0;
                    w_retry_d      = '0;
                    if (w_req_len == 5'd0) begin
                        w_state_d = StFinish;
                    end else if (io_bus.req_rw) begin
                        w_state_d = StIssue;
                    end else begin
                        w_state_d = StFetch;
                    end
                end
            end
            StFetch: begin
                if (io_bus.wr_valid) begin
                    w_din_d   = io_bus.wr_data;
                    w_state_d = StIssue;
                end
            end
            StIssue: w_state_d = StWait;
            StWait: begin
                // An error wins over a simultaneous byte_done.
                if (io_bus.m_error) begin
                    if (r_retry < 8'(MAX_RETRY)) begin
                        w_retry_d = r_retry + 8'd1;
                        w_state_d = StIssue;
                    end else begin
                        w_fail_d  = 1'b1;
                        w_state_d = StIdle;
                    end
                end else if (io_bus.m_byte_done) begin
                    if (r_rw) begin
                        w_rd_data_d = io_bus.m_dout;
                        w_state_d   = StDeliver;
                    end else begin
                        w_gap_load = 1'b1;
                        w_state_d  = StGap;
                    end
                end
            end
            StDeliver: w_advance = io_bus.rd_ready;
            StGap:     w_advance = w_gap_expire;
            StFinish:  w_state_d = StIdle;
            default:   w_state_d = StIdle;
        endcase

        if (w_advance) begin
            w_bytes_done_d = w_bytes_inc;
            w_retry_d      = '0;
            w_byte_addr_d  = r_byte_addr + 8'd1;
            if (w_bytes_inc == r_len) begin
                w_state_d = StFinish;
            end else if (r_rw) begin
                w_state_d = StIssue;
            end else begin
                w_state_d = StFetch;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_live       <= 1'b0;
            r_rw         <= 1'b0;
            r_addr       <= '0;
            r_byte_addr  <= '0;
            r_din        <= '0;
            r_rd_data    <= '0;
            r_len        <= '0;
            r_bytes_done <= '0;
            r_retry      <= '0;
            r_fail       <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_live       <= 1'b1;
            r_rw         <= w_rw_d;
            r_addr       <= w_addr_d;
            r_byte_addr  <= w_byte_addr_d;
            r_din        <= w_din_d;
            r_rd_data    <= w_rd_data_d;
            r_len        <= w_len_d;
            r_bytes_done <= w_bytes_done_d;
            r_retry      <= w_retry_d;
            r_fail       <= w_fail_d;
        end
    end

    i2c_block_sequencer_gap_timer #(
        .CYCLES (WR_GAP)
    ) u_gap_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (w_gap_load),
        .i_count  (r_state == StGap),
        .o_expire (w_gap_expire)
    );

    assign io_bus.req_ready      = w_req_ready;
    assign io_bus.wr_ready       = (r_state == StFetch) && !i_rst;
    assign io_bus.rd_valid       = (r_state == StDeliver) && !i_rst;
    assign io_bus.rd_data        = r_rd_data;
    assign io_bus.done           = (r_state == StFinish) && !i_rst;
    assign io_bus.fail           = r_fail;
    assign io_bus.bytes_done     = r_bytes_done;
    assign io_bus.m_start        = (r_state == StIssue) && !i_rst;
    assign io_bus.m_rw           = r_rw;
    assign io_bus.m_addr         = r_addr;
    assign io_bus.m_byte_address = r_byte_addr;
    assign io_bus.m_din          = r_din;

endmodule

// File: tb/tb_i2c_block_sequencer.sv
// Directed bench for i2c_block_sequencer: read, write, retry, abort, backpressure, reset, len 0/clamp.
module tb_i2c_block_sequencer;

    localparam int unsigned TbRetry = 3;
    localparam int unsigned TbGap   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2c_block_sequencer_if bus ();

    i2c_block_sequencer #(
        .MAX_RETRY (TbRetry),
        .WR_GAP    (TbGap)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int n_mstart = 0;
    int n_done   = 0;
    int n_fail   = 0;
    int bm, bd, bf, bad;

    // Pulse counters sample the pre-edge value of each output.
    always @(posedge clk) begin
        if (bus.m_start === 1'b1) n_mstart <= n_mstart + 1;
        if (bus.done === 1'b1)    n_done   <= n_done + 1;
        if (bus.fail === 1'b1)    n_fail   <= n_fail + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input logic rw, input logic [7:0] start, input logic [4:0] len);
        bus.req_rw    = rw;
        bus.req_addr  = 7'h50;
        bus.req_start = start;
        bus.req_len   = len;
        bus.req_valid = 1'b1;
        check("req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_mstart(input string tag);
        int n = 0;
        while (bus.m_start !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_mstart"}, 32'(bus.m_start), 32'd1);
    endtask

    task automatic resp(input logic err, input logic bdone, input logic [7:0] dout);
        bus.m_error     = err;
        bus.m_byte_done = bdone;
        bus.m_dout      = dout;
        @(negedge clk);
        bus.m_error     = 1'b0;
        bus.m_byte_done = 1'b0;
    endtask

    task automatic rd_byte(input string tag, input logic [7:0] exp_ba, input logic [7:0] dout);
        wait_mstart(tag);
        check({tag, "_ba"}, 32'(bus.m_byte_address), 32'(exp_ba));
        check({tag, "_rw"}, 32'(bus.m_rw), 32'd1);
        check({tag, "_maddr"}, 32'(bus.m_addr), 32'h50);
        @(negedge clk);
        resp(1'b0, 1'b1, dout);
        check({tag, "_rdv"}, 32'(bus.rd_valid), 32'd1);
        check({tag, "_rdd"}, 32'(bus.rd_data), 32'(dout));
        bus.rd_ready = 1'b1;
        @(negedge clk);
        bus.rd_ready = 1'b0;
    endtask

    task automatic wr_byte(input string tag, input logic [7:0] exp_ba, input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        check({tag, "_wrrdy"}, 32'(bus.wr_ready), 32'd1);
        bus.wr_data  = d;
        bus.wr_valid = 1'b1;
        @(negedge clk);
        bus.wr_valid = 1'b0;
        wait_mstart(tag);
        check({tag, "_ba"}, 32'(bus.m_byte_address), 32'(exp_ba));
        check({tag, "_din"}, 32'(bus.m_din), 32'(d));
        check({tag, "_rw"}, 32'(bus.m_rw), 32'd0);
        @(negedge clk);
        resp(1'b0, 1'b1, 8'h00);
        while (bus.wr_ready !== 1'b1 && bus.done !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_gap"}, 32'(n), 32'(TbGap));
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_rw = 1'b0; bus.req_addr = '0; bus.req_start = '0;
        bus.req_len = '0; bus.wr_data = '0; bus.wr_valid = 1'b0; bus.rd_ready = 1'b0;
        bus.m_dout = '0; bus.m_byte_done = 1'b0; bus.m_error = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_m_start", 32'(bus.m_start), 32'd0);
        check("rst_bytes_done", 32'(bus.bytes_done), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        check("rel_req_ready_same_cycle", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        check("rel_req_ready_next_cycle", 32'(bus.req_ready), 32'd1);

        // Read block 0x10..0x12
        bm = n_mstart; bd = n_done;
        send_req(1'b1, 8'h10, 5'd3);
        check("t1_bytes_clr", 32'(bus.bytes_done), 32'd0);
        rd_byte("t1_b0", 8'h10, 8'hA1);
        rd_byte("t1_b1", 8'h11, 8'hA2);
        rd_byte("t1_b2", 8'h12, 8'hA3);
        check("t1_done_now", 32'(bus.done), 32'd1);
        @(negedge clk);
        check("t1_bytes", 32'(bus.bytes_done), 32'd3);
        check("t1_mstarts", 32'(n_mstart - bm), 32'd3);
        check("t1_dones", 32'(n_done - bd), 32'd1);
        check("t1_idle", 32'(bus.req_ready), 32'd1);

        // Write block wrapping 0xFE -> 0x00
        bm = n_mstart; bd = n_done;
        send_req(1'b0, 8'hFE, 5'd3);
        wr_byte("t2_b0", 8'hFE, 8'h11);
        wr_byte("t2_b1", 8'hFF, 8'h22);
        wr_byte("t2_b2", 8'h00, 8'h33);
        check("t2_done_now", 32'(bus.done), 32'd1);
        @(negedge clk);
        check("t2_bytes", 32'(bus.bytes_done), 32'd3);
        check("t2_mstarts", 32'(n_mstart - bm), 32'd3);
        check("t2_dones", 32'(n_done - bd), 32'd1);

        // Two errors on second byte, then success
        bm = n_mstart; bd = n_done; bf = n_fail;
        send_req(1'b1, 8'h20, 5'd3);
        rd_byte("t3_b0", 8'h20, 8'h31);
        for (int i = 0; i < 2; i++) begin
            wait_mstart("t3_retry");
            check("t3_retry_ba", 32'(bus.m_byte_address), 32'h21);
            @(negedge clk);
            resp(1'b1, 1'b0, 8'h00);
        end
        rd_byte("t3_b1", 8'h21, 8'h32);
        rd_byte("t3_b2", 8'h22, 8'h33);
        @(negedge clk);
        check("t3_bytes", 32'(bus.bytes_done), 32'd3);
        check("t3_mstarts", 32'(n_mstart - bm), 32'd5);
        check("t3_dones", 32'(n_done - bd), 32'd1);
        check("t3_no_fail", 32'(n_fail - bf), 32'd0);

        // Four errors in a row abort the block; one error coincides with byte_done
        bm = n_mstart; bd = n_done; bf = n_fail;
        send_req(1'b1, 8'h30, 5'd2);
        rd_byte("t4_b0", 8'h30, 8'h41);
        for (int i = 0; i < 4; i++) begin
            wait_mstart("t4_err");
            check("t4_err_ba", 32'(bus.m_byte_address), 32'h31);
            @(negedge clk);
            resp(1'b1, (i == 1), 8'h00);
        end
        check("t4_fail_pulse", 32'(bus.fail), 32'd1);
        check("t4_req_ready", 32'(bus.req_ready), 32'd1);
        check("t4_bytes", 32'(bus.bytes_done), 32'd1);
        check("t4_no_rdv", 32'(bus.rd_valid), 32'd0);
        @(negedge clk);
        check("t4_fail_clear", 32'(bus.fail), 32'd0);
        check("t4_fails", 32'(n_fail - bf), 32'd1);
        check("t4_no_done", 32'(n_done - bd), 32'd0);
        check("t4_mstarts", 32'(n_mstart - bm), 32'd5);

        // rd_ready held low for 50 cycles
        send_req(1'b1, 8'h40, 5'd1);
        wait_mstart("t5");
        @(negedge clk);
        resp(1'b0, 1'b1, 8'h5A);
        bm = n_mstart; bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h5A) bad++;
            @(negedge clk);
        end
        check("t5_unstable_cycles", 32'(bad), 32'd0);
        check("t5_no_mstart", 32'(n_mstart - bm), 32'd0);
        bus.rd_ready = 1'b1;
        @(negedge clk);
        bus.rd_ready = 1'b0;
        check("t5_done", 32'(bus.done), 32'd1);
        @(negedge clk);

        // Reset while waiting on the master
        send_req(1'b1, 8'h60, 5'd2);
        wait_mstart("t6");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_req_ready", 32'(bus.req_ready), 32'd0);
        check("t6_m_start", 32'(bus.m_start), 32'd0);
        check("t6_m_rw", 32'(bus.m_rw), 32'd0);
        check("t6_m_addr", 32'(bus.m_addr), 32'd0);
        check("t6_m_ba", 32'(bus.m_byte_address), 32'd0);
        check("t6_bytes", 32'(bus.bytes_done), 32'd0);
        check("t6_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("t6_rd_data", 32'(bus.rd_data), 32'd0);
        check("t6_done_fail", 32'({bus.done, bus.fail, bus.wr_ready}), 32'd0);
        bm = n_mstart;
        rst = 1'b0;
        @(negedge clk);
        check("t6_req_ready_after", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        check("t6_no_mstart", 32'(n_mstart - bm), 32'd0);

        // len 0: done without bus activity
        bm = n_mstart; bd = n_done;
        send_req(1'b1, 8'h70, 5'd0);
        check("t7_done_now", 32'(bus.done), 32'd1);
        @(negedge clk);
        check("t7_bytes", 32'(bus.bytes_done), 32'd0);
        check("t7_dones", 32'(n_done - bd), 32'd1);
        check("t7_no_mstart", 32'(n_mstart - bm), 32'd0);
        check("t7_idle", 32'(bus.req_ready), 32'd1);

        // len 20 clamps to 16
        bm = n_mstart;
        send_req(1'b1, 8'h80, 5'd20);
        for (int i = 0; i < 16; i++) begin
            rd_byte("t8", 8'h80 + 8'(i), 8'(i));
        end
        check("t8_done_now", 32'(bus.done), 32'd1);
        @(negedge clk);
        check("t8_bytes", 32'(bus.bytes_done), 32'd16);
        check("t8_mstarts", 32'(n_mstart - bm), 32'd16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/i2c_block_sequencer.md
I2C_BLOCK_SEQUENCER -- requirements
Module: i2c_block_sequencer

Interface
REQ-001 Parameter MAX_RETRY, default 3: max re-issues of one byte after master error.
REQ-002 Parameter WR_GAP, default 100000: idle clk cycles after each written byte (EEPROM write-cycle time).
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req_valid / req_ready  in / out  1  block-request handshake; transfer when both are high.
REQ-006 req_rw  in  1  1 = read, 0 = write.
REQ-007 req_addr  in  7  EEPROM device address.
REQ-008 req_start  in  8  first byte address.
REQ-009 req_len  in  5  byte count, 0..16.
REQ-010 wr_data  in  8; wr_valid  in  1; wr_ready  out  1  write-data stream.
REQ-011 rd_data  out  8; rd_valid  out  1; rd_ready  in  1  read-data stream.
REQ-012 done / fail  out  1  one-cycle completion / abort pulses.
REQ-013 bytes_done  out  5  bytes completed in the current or last block.
REQ-014 m_start out 1; m_rw out 1; m_addr out 7; m_byte_address out 8; m_din out 8  drive i2c_master.
REQ-015 m_dout in 8; m_byte_done in 1; m_error in 1  results from i2c_master.

Function
REQ-016 States SHALL be IDLE, FETCH, ISSUE, WAIT, DELIVER, GAP, FINISH.
REQ-017 IDLE SHALL assert req_ready and latch rw/addr/start/len on handshake; len 0 goes directly to FINISH with no bus activity.
REQ-018 FETCH (write only) SHALL assert wr_ready, capture wr_data into m_din on handshake, then go to ISSUE; it waits indefinitely for wr_valid.
REQ-019 ISSUE SHALL pulse m_start high for exactly one cycle, then go to WAIT.
REQ-020 m_rw, m_addr, m_byte_address, m_din SHALL hold stable from ISSUE until leaving WAIT.
REQ-021 WAIT, on m_byte_done: read goes to DELIVER with m_dout captured to rd_data; write goes to GAP.
REQ-022 WAIT, on m_error: if retry count < MAX_RETRY, increment it and return to ISSUE with the same byte; otherwise pulse fail and go to IDLE.
REQ-023 m_error and m_byte_done in the same cycle SHALL be treated as an error.
REQ-024 DELIVER SHALL hold rd_valid with stable rd_data until rd_ready, with no timeout.
REQ-025 GAP SHALL count WR_GAP cycles.
REQ-026 After DELIVER handshake or GAP expiry: increment bytes_done, clear retry count, increment m_byte_address mod 256 (0xFF wraps to 0x00); go to FINISH if bytes_done equals len, else FETCH (write) or ISSUE (read).
REQ-027 FINISH SHALL pulse done for one cycle and return to IDLE.
REQ-028 bytes_done SHALL clear on request acceptance and hold its value in IDLE.
REQ-029 req_len > 16 SHALL be clamped to 16.
REQ-030 Throughput SHALL be one byte per i2c_master transaction; start to first m_start is at most 2 cycles for reads.

Reset
REQ-031 rst SHALL force IDLE at any point, including mid-transaction.
REQ-032 All outputs SHALL reset to 0 except req_ready, which becomes 1 in the cycle after rst deasserts.
REQ-033 Retry and GAP counters SHALL clear on rst; m_start SHALL never pulse during or in the cycle after rst.

Structure
REQ-034 The state encoding, MAX_LEN = 16 and default timing constants SHALL live in shared package i2c_pkg.
REQ-035 A single sub-module, gap_timer (load/count/expire), is natural; all other logic SHALL stay flat.
REQ-036 Target size is 150-300 lines.

Verification
REQ-037 Read, addr 0x50, start 0x10, len 3, master model returns 0xA1/0xA2/0xA3 -> three m_start pulses with m_byte_address 0x10/0x11/0x12, rd_data in order, done once, bytes_done = 3.
REQ-038 Write, start 0xFE, len 3, data 0x11/0x22/0x33 -> m_byte_address 0xFE/0xFF/0x00, WR_GAP idle cycles after each byte, done.
REQ-039 m_error on the second byte twice, then success, MAX_RETRY = 3 -> byte re-issued at the same address, block completes, no fail pulse.
REQ-040 m_error four times in a row -> fail pulse after the 4th error, bytes_done = 1, IDLE with req_ready = 1.
REQ-041 rd_ready held low for 50 cycles -> rd_valid and rd_data stable throughout, no new m_start.
REQ-042 rst asserted in WAIT, and separately len = 0 -> all outputs 0 then IDLE; for len 0, done with zero m_start pulses.
